// File: rtl/fpu_result_scoreboard.sv
// In-order result scoreboard: queues reference results, compares them against
// RTL results under a ULP tolerance, keeps statistics and captures the first
// failing transaction.

package fpu_sb_pkg;
  typedef struct packed {
    logic        sign;
    logic [7:0]  expn;
    logic [22:0] frac;
  } real_t;
endpackage

module fpu_result_scoreboard
  import fpu_sb_pkg::*;
#(
  parameter int N_CH    = 3,
  parameter int DEPTH   = 16,
  parameter int ULP_TOL = 1,
  parameter int CNT_W   = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_clr,
  input  logic                          i_ref_vld,
  input  real_t [N_CH-1:0]              i_ref,
  output logic                          o_ref_rdy,
  input  logic                          i_rtl_vld,
  input  real_t [N_CH-1:0]              i_rtl,
  output logic [$clog2(DEPTH):0]        o_level,
  output logic [CNT_W-1:0]              o_cmp_cnt,
  output logic [N_CH-1:0][CNT_W-1:0]    o_err_cnt,
  output logic [CNT_W-1:0]              o_unexp_cnt,
  output logic                          o_err,
  output logic [CNT_W-1:0]              o_first_idx,
  output logic [N_CH-1:0]               o_first_mask,
  output real_t [N_CH-1:0]              o_first_ref,
  output real_t [N_CH-1:0]              o_first_rtl
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // Reference FIFO state
  real_t [N_CH-1:0]           r_mem [DEPTH];
  logic [AW-1:0]              r_wptr;
  logic [AW-1:0]              r_rptr;
  logic [LW-1:0]              r_level;

  // Pipeline registers
  logic                       r_s0_vld;
  logic                       r_s0_unexp;
  real_t [N_CH-1:0]           r_s0_ref;
  real_t [N_CH-1:0]           r_s0_rtl;
  logic                       r_s1_vld;
  logic [N_CH-1:0]            r_s1_mask;
  real_t [N_CH-1:0]           r_s1_ref;
  real_t [N_CH-1:0]           r_s1_rtl;

  // Statistics and capture
  logic [CNT_W-1:0]           r_cmp_cnt;
  logic [N_CH-1:0][CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0]           r_unexp_cnt;
  logic                       r_err;
  logic [CNT_W-1:0]           r_first_idx;
  logic [N_CH-1:0]            r_first_mask;
  real_t [N_CH-1:0]           r_first_ref;
  real_t [N_CH-1:0]           r_first_rtl;

  logic                       w_push;
  logic                       w_pop;
  logic                       w_unexp;
  logic                       w_empty;
  logic [N_CH-1:0]            w_mask;

  // Handshake: the reference side transfers on a cycle where i_ref_vld and
  // o_ref_rdy are both high; o_ref_rdy does not depend on i_ref_vld. The RTL
  // side has no ready: every i_rtl_vld cycle consumes the FIFO head, or is
  // counted as unexpected when the FIFO is empty. A full FIFO still accepts a
  // push when the RTL side pops in the same cycle.
  assign w_empty   = (r_level == '0);
  assign o_ref_rdy = (r_level != LW'(DEPTH)) || i_rtl_vld;
  assign w_push    = i_ref_vld && o_ref_rdy;
  assign w_pop     = i_rtl_vld && !w_empty;
  assign w_unexp   = i_rtl_vld && w_empty;

  // Channel failure rule: specials need bitwise equality, otherwise the
  // sign-aware magnitude distance must stay within ULP_TOL.
  function automatic logic chan_fail(input real_t a, input real_t b);
    logic [30:0] ma;
    logic [30:0] mb;
    logic [31:0] d;
    ma = {a.expn, a.frac};
    mb = {b.expn, b.frac};
    if ((&a.expn) || (&b.expn)) begin
      chan_fail = (a != b);
    end else begin
      if (a.sign == b.sign) begin
        d = (ma >= mb) ? {1'b0, ma - mb} : {1'b0, mb - ma};
      end else begin
        d = {1'b0, ma} + {1'b0, mb};
      end
      chan_fail = (d > 32'(ULP_TOL));
    end
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + CNT_W'(1);
  endfunction

  // FIFO storage write; contents need no reset since the level gates reads
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_ref;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Stage 0 valid flags: popped transaction and unexpected arrival
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0_vld   <= 1'b0;
      r_s0_unexp <= 1'b0;
    end else begin
      r_s0_vld   <= w_pop;
      r_s0_unexp <= w_unexp;
    end
  end

  // Stage 0 operands: FIFO head and the RTL result
  always_ff @(posedge clk) begin
    if (w_pop) begin
      r_s0_ref <= r_mem[r_rptr];
      r_s0_rtl <= i_rtl;
    end
  end

  // Per-channel fail mask of the stage-0 transaction
  always_comb begin
    w_mask = '0;
    for (int c = 0; c < N_CH; c++) begin
      w_mask[c] = chan_fail(r_s0_ref[c], r_s0_rtl[c]);
    end
  end

  // Stage 1 valid flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld <= 1'b0;
    end else begin
      r_s1_vld <= r_s0_vld;
    end
  end

  // Stage 1 mask and operands
  always_ff @(posedge clk) begin
    if (r_s0_vld) begin
      r_s1_mask <= w_mask;
      r_s1_ref  <= r_s0_ref;
      r_s1_rtl  <= r_s0_rtl;
    end
  end

  // Statistics, sticky error and first-failure capture; clear wins over update
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cmp_cnt    <= '0;
      r_err_cnt    <= '0;
      r_unexp_cnt  <= '0;
      r_err        <= 1'b0;
      r_first_idx  <= '0;
      r_first_mask <= '0;
      r_first_ref  <= '0;
      r_first_rtl  <= '0;
    end else begin
      if (r_s1_vld) begin
        r_cmp_cnt <= sat_inc(r_cmp_cnt);
        for (int c = 0; c < N_CH; c++) begin
          if (r_s1_mask[c]) r_err_cnt[c] <= sat_inc(r_err_cnt[c]);
        end
        if (|r_s1_mask) begin
          r_err <= 1'b1;
          if (!r_err) begin
            r_first_idx  <= r_cmp_cnt;
            r_first_mask <= r_s1_mask;
            r_first_ref  <= r_s1_ref;
            r_first_rtl  <= r_s1_rtl;
          end
        end
      end
      if (r_s0_unexp) begin
        r_unexp_cnt <= sat_inc(r_unexp_cnt);
        r_err       <= 1'b1;
      end
    end
  end

  assign o_level      = r_level;
  assign o_cmp_cnt    = r_cmp_cnt;
  assign o_err_cnt    = r_err_cnt;
  assign o_unexp_cnt  = r_unexp_cnt;
  assign o_err        = r_err;
  assign o_first_idx  = r_first_idx;
  assign o_first_mask = r_first_mask;
  assign o_first_ref  = r_first_ref;
  assign o_first_rtl  = r_first_rtl;

endmodule

// File: tb/tb_fpu_result_scoreboard.sv
// Directed bench for fpu_result_scoreboard with hand-computed expectations.

module tb_fpu_result_scoreboard;
  import fpu_sb_pkg::*;

  typedef real_t [2:0] vec_t;

  logic        clk;
  logic        rst;
  logic        i_clr;
  logic        i_ref_vld;
  vec_t        i_ref;
  logic        o_ref_rdy;
  logic        i_rtl_vld;
  vec_t        i_rtl;
  logic [4:0]  o_level;
  logic [31:0] o_cmp_cnt;
  logic [2:0][31:0] o_err_cnt;
  logic [31:0] o_unexp_cnt;
  logic        o_err;
  logic [31:0] o_first_idx;
  logic [2:0]  o_first_mask;
  vec_t        o_first_ref;
  vec_t        o_first_rtl;

  int checks = 0;
  int errors = 0;

  fpu_result_scoreboard #(.N_CH(3), .DEPTH(16), .ULP_TOL(1), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .i_clr(i_clr),
    .i_ref_vld(i_ref_vld), .i_ref(i_ref), .o_ref_rdy(o_ref_rdy),
    .i_rtl_vld(i_rtl_vld), .i_rtl(i_rtl),
    .o_level(o_level), .o_cmp_cnt(o_cmp_cnt), .o_err_cnt(o_err_cnt),
    .o_unexp_cnt(o_unexp_cnt), .o_err(o_err), .o_first_idx(o_first_idx),
    .o_first_mask(o_first_mask), .o_first_ref(o_first_ref), .o_first_rtl(o_first_rtl)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk3(input logic [31:0] c2, input logic [31:0] c1, input logic [31:0] c0);
    return {real_t'(c2), real_t'(c1), real_t'(c0)};
  endfunction

  function automatic vec_t fill(input int k);
    logic [31:0] v;
    v = 32'h3F800000 + 32'(8 * k);
    return mk3(v, v, v);
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock: active edge, then settle to the falling edge for checks
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input vec_t v);
    i_ref_vld = 1'b1;
    i_ref     = v;
    step();
    i_ref_vld = 1'b0;
  endtask

  task automatic pop(input vec_t v);
    i_rtl_vld = 1'b1;
    i_rtl     = v;
    step();
    i_rtl_vld = 1'b0;
  endtask

  task automatic clear();
    i_clr = 1'b1;
    step();
    i_clr = 1'b0;
  endtask

  vec_t one3;
  vec_t tol_ref, tol_rtl;
  vec_t sp1_ref, sp1_rtl, sp2_ref, sp2_rtl;
  vec_t bad3;

  initial begin
    one3    = mk3(32'h3F800000, 32'h3F800000, 32'h3F800000);
    tol_ref = mk3(32'h007FFFFF, 32'h3F800000, 32'h3F800000);
    tol_rtl = mk3(32'h00800000, 32'h3F800002, 32'h3F800001);
    sp1_ref = mk3(32'h7F800000, 32'h3F800000, 32'h00000000);
    sp1_rtl = mk3(32'h7F800000, 32'hBF800000, 32'h80000000);
    sp2_ref = mk3(32'h3F800000, 32'h3F800000, 32'h7FC00000);
    sp2_rtl = mk3(32'h3F800000, 32'h3F800000, 32'h7FC00001);
    bad3    = mk3(32'h3F800005, 32'h3F800000, 32'h3F800000);

    rst = 1'b1; i_clr = 1'b0; i_ref_vld = 1'b0; i_rtl_vld = 1'b0;
    i_ref = '0; i_rtl = '0;
    step(); step();
    rst = 1'b0;

    // Reset state
    chk("rst_level", 128'(o_level), 128'(0));
    chk("rst_rdy", 128'(o_ref_rdy), 128'(1));
    chk("rst_cmp", 128'(o_cmp_cnt), 128'(0));
    chk("rst_err", 128'(o_err), 128'(0));
    chk("rst_unexp", 128'(o_unexp_cnt), 128'(0));
    chk("rst_mask", 128'(o_first_mask), 128'(0));

    // Exact match: 5 pushes, gap of 3, 5 returns; checks latency and throughput
    for (int k = 0; k < 5; k++) push(one3);
    chk("exact_level5", 128'(o_level), 128'(5));
    step(); step(); step();
    i_rtl_vld = 1'b1; i_rtl = one3;
    step(); chk("lat_n", 128'(o_cmp_cnt), 128'(0));
    step(); chk("lat_n1", 128'(o_cmp_cnt), 128'(0));
    step(); chk("lat_n2", 128'(o_cmp_cnt), 128'(1));
    step(); chk("thru_2", 128'(o_cmp_cnt), 128'(2));
    step(); chk("thru_3", 128'(o_cmp_cnt), 128'(3));
    i_rtl_vld = 1'b0;
    step(); step();
    chk("exact_cmp", 128'(o_cmp_cnt), 128'(5));
    chk("exact_errcnt", 128'(o_err_cnt), 128'(0));
    chk("exact_err", 128'(o_err), 128'(0));
    chk("exact_level0", 128'(o_level), 128'(0));

    // Tolerance boundary: ch0 1 ULP pass, ch1 2 ULP fail, ch2 exponent crossing pass
    push(tol_ref);
    pop(tol_rtl);
    step(); step();
    chk("tol_cmp", 128'(o_cmp_cnt), 128'(6));
    chk("tol_err0", 128'(o_err_cnt[0]), 128'(0));
    chk("tol_err1", 128'(o_err_cnt[1]), 128'(1));
    chk("tol_err2", 128'(o_err_cnt[2]), 128'(0));
    chk("tol_err", 128'(o_err), 128'(1));
    chk("tol_mask", 128'(o_first_mask), 128'(3'b010));
    chk("tol_idx", 128'(o_first_idx), 128'(5));
    chk("tol_fref", 128'(o_first_ref), 128'(tol_ref));
    chk("tol_frtl", 128'(o_first_rtl), 128'(tol_rtl));

    // Clear with empty FIFO
    clear();
    chk("clr_cmp", 128'(o_cmp_cnt), 128'(0));
    chk("clr_err", 128'(o_err), 128'(0));
    chk("clr_errcnt", 128'(o_err_cnt), 128'(0));
    chk("clr_mask", 128'(o_first_mask), 128'(0));

    // Signed zero and specials: +0/-0 pass, +1/-1 fail, inf/inf pass, NaN/NaN+1 fail
    push(sp1_ref);
    push(sp2_ref);
    pop(sp1_rtl);
    pop(sp2_rtl);
    step(); step();
    chk("sp_cmp", 128'(o_cmp_cnt), 128'(2));
    chk("sp_err0", 128'(o_err_cnt[0]), 128'(1));
    chk("sp_err1", 128'(o_err_cnt[1]), 128'(1));
    chk("sp_err2", 128'(o_err_cnt[2]), 128'(0));
    chk("sp_mask", 128'(o_first_mask), 128'(3'b010));
    chk("sp_idx", 128'(o_first_idx), 128'(0));

    // Clear with 3 entries queued keeps the FIFO
    for (int k = 0; k < 3; k++) push(one3);
    clear();
    chk("clrq_level", 128'(o_level), 128'(3));
    chk("clrq_cmp", 128'(o_cmp_cnt), 128'(0));
    chk("clrq_err", 128'(o_err), 128'(0));
    chk("clrq_errcnt", 128'(o_err_cnt), 128'(0));
    chk("clrq_idx", 128'(o_first_idx), 128'(0));

    // First-error capture: transactions #3 and #7 fail on ch2
    for (int k = 0; k < 5; k++) push(one3);
    chk("fe_level", 128'(o_level), 128'(8));
    for (int k = 0; k < 8; k++) pop((k == 3 || k == 7) ? bad3 : one3);
    step(); step();
    chk("fe_cmp", 128'(o_cmp_cnt), 128'(8));
    chk("fe_idx", 128'(o_first_idx), 128'(3));
    chk("fe_mask", 128'(o_first_mask), 128'(3'b100));
    chk("fe_err2", 128'(o_err_cnt[2]), 128'(2));
    chk("fe_frtl", 128'(o_first_rtl), 128'(bad3));
    chk("fe_fref", 128'(o_first_ref), 128'(one3));

    // Full FIFO
    clear();
    for (int k = 0; k < 16; k++) push(fill(k));
    chk("full_level", 128'(o_level), 128'(16));
    #1 chk("full_rdy0", 128'(o_ref_rdy), 128'(0));
    i_ref_vld = 1'b1; i_ref = fill(16);
    i_rtl_vld = 1'b1; i_rtl = fill(0);
    #1 chk("full_rdy_pop", 128'(o_ref_rdy), 128'(1));
    step();
    chk("full_level_pp", 128'(o_level), 128'(16));
    i_rtl_vld = 1'b0; i_ref = mk3(32'h40000000, 32'h40000000, 32'h40000000);
    #1 chk("full_rdy_nopop", 128'(o_ref_rdy), 128'(0));
    step();
    i_ref_vld = 1'b0;
    chk("full_level_ign", 128'(o_level), 128'(16));
    for (int k = 1; k <= 16; k++) pop(fill(k));
    step(); step();
    chk("drain_level", 128'(o_level), 128'(0));
    chk("drain_cmp", 128'(o_cmp_cnt), 128'(17));
    chk("drain_errcnt", 128'(o_err_cnt), 128'(0));
    chk("drain_err", 128'(o_err), 128'(0));

    // Unexpected result on empty FIFO
    clear();
    pop(one3);
    chk("unx_n_cnt", 128'(o_unexp_cnt), 128'(0));
    chk("unx_n_err", 128'(o_err), 128'(0));
    step();
    chk("unx_cnt", 128'(o_unexp_cnt), 128'(1));
    chk("unx_err", 128'(o_err), 128'(1));
    chk("unx_mask", 128'(o_first_mask), 128'(0));
    chk("unx_level", 128'(o_level), 128'(0));

    // Push plus RTL arrival on empty FIFO: no bypass
    i_ref_vld = 1'b1; i_ref = one3;
    i_rtl_vld = 1'b1; i_rtl = one3;
    step();
    i_ref_vld = 1'b0; i_rtl_vld = 1'b0;
    chk("nobyp_level", 128'(o_level), 128'(1));
    step();
    chk("nobyp_unexp", 128'(o_unexp_cnt), 128'(2));
    chk("nobyp_cmp0", 128'(o_cmp_cnt), 128'(0));
    pop(one3);
    step(); step();
    chk("nobyp_cmp", 128'(o_cmp_cnt), 128'(1));
    chk("nobyp_errcnt", 128'(o_err_cnt), 128'(0));
    chk("nobyp_mask", 128'(o_first_mask), 128'(0));

    // Reset with 4 entries queued
    for (int k = 0; k < 4; k++) push(one3);
    chk("rq_level4", 128'(o_level), 128'(4));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rq_level0", 128'(o_level), 128'(0));
    chk("rq_rdy", 128'(o_ref_rdy), 128'(1));
    chk("rq_cmp", 128'(o_cmp_cnt), 128'(0));
    chk("rq_unexp", 128'(o_unexp_cnt), 128'(0));
    chk("rq_err", 128'(o_err), 128'(0));
    step(); step();
    chk("rq_cmp_late", 128'(o_cmp_cnt), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
